// File: rtl/shared_bus_arbiter.sv
// ---------------------------------------------------------------------------
// shared_bus_arbiter
//
// Purpose:
//   Round-robin arbiter for a single shared bus with four requesters.
//   An idle bus is granted to the first active requester found by searching
//   upward from a rotating pointer. The owner then keeps the bus until it
//   drops its request. A mandatory one-cycle bubble (grant = 0) always
//   separates two owners.
//
//   When the SHARED_BUS_ARBITER_TIMEOUT_EN macro is defined, a contended
//   owner is revoked after holding the bus for MAX_HOLD cycles.
//   timeout_pulse marks the bubble cycle that follows such a forced revoke.
//   When the macro is undefined, the hold counter is not built and the owner
//   keeps the bus for as long as it requests it. The port list is the same
//   in both builds.
//
// Parameters:
//   MAX_HOLD      : grant cycles before a contended owner is revoked (1..255)
//
// Ports:
//   clk           : in  single clock, rising-edge active
//   reset_n       : in  synchronous active-low reset
//   req[3:0]      : in  per-requester request, held high while the bus is needed
//   grant[3:0]    : out registered one-hot (or zero) grant vector
//   grant_valid   : out registered, high when any grant bit is high
//   grant_id[1:0] : out index of the current owner, 0 when no grant
//   timeout_pulse : out one-cycle pulse on the cycle after a forced revoke
//
// Configuration macro:
//   SHARED_BUS_ARBITER_TIMEOUT_EN : compiles in the forced-revoke logic
// ---------------------------------------------------------------------------
module shared_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  output logic       timeout_pulse
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q,       state_d;
  logic [1:0] pointer_q,     pointer_d;
  logic [3:0] grant_q,       grant_d;
  logic       grant_valid_q, grant_valid_d;
  logic [1:0] grant_id_q,    grant_id_d;

  logic       sel_found;
  logic [1:0] sel_idx;
  logic       owner_req;
  logic       other_req;

`ifdef SHARED_BUS_ARBITER_TIMEOUT_EN
  localparam logic [7:0] MaxHoldC = 8'(MAX_HOLD);

  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q,  timeout_d;
  logic       hold_expired;
`else
  // MAX_HOLD only matters when the revoke logic is built.
  logic [31:0] unused_max_hold;
  assign unused_max_hold = 32'(MAX_HOLD);
`endif

  // Rotating priority search. The candidate index is pointer + k in 2-bit
  // arithmetic, so the search wraps naturally from requester 3 back to 0.
  // Only the first active candidate is kept.
  always_comb begin
    logic [1:0] cand;
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = pointer_q + 2'(k);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Request status of the current owner and of everybody else. The grant
  // register is one-hot, so masking with it isolates the non-owners.
  assign owner_req = req[grant_id_q];
  assign other_req = |(req & ~grant_q);

`ifdef SHARED_BUS_ARBITER_TIMEOUT_EN
  assign hold_expired = (hold_cnt_q == MaxHoldC);
`endif

  // Next-state and next-output logic. Every path that leaves GRANT goes
  // through IDLE with a zero grant, which produces the bubble cycle between
  // owners. The IDLE branch also arbitrates during that bubble. A new
  // owner is therefore visible one cycle after the bubble.
  always_comb begin
    state_d    = state_q;
    pointer_d  = pointer_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
`ifdef SHARED_BUS_ARBITER_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d    = GRANT;
          grant_d    = 4'b0001 << sel_idx;
          grant_id_d = sel_idx;
          pointer_d  = sel_idx + 2'd1;
`ifdef SHARED_BUS_ARBITER_TIMEOUT_EN
          hold_cnt_d = 8'd1;
`endif
        end else begin
          grant_d    = 4'b0000;
          grant_id_d = 2'd0;
        end
      end

      GRANT: begin
        if (!owner_req) begin
          // A voluntary release takes priority over a revoke that would
          // fire on the same cycle, so no timeout pulse is raised.
          state_d    = IDLE;
          grant_d    = 4'b0000;
          grant_id_d = 2'd0;
`ifdef SHARED_BUS_ARBITER_TIMEOUT_EN
          hold_cnt_d = 8'd0;
`endif
        end
`ifdef SHARED_BUS_ARBITER_TIMEOUT_EN
        else if (hold_expired && other_req) begin
          state_d    = IDLE;
          grant_d    = 4'b0000;
          grant_id_d = 2'd0;
          hold_cnt_d = 8'd0;
          timeout_d  = 1'b1;
        end else if (!hold_expired) begin
          // The counter saturates at MAX_HOLD. An uncontended owner
          // simply stays there and keeps the bus.
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
`endif
      end

      default: begin
        state_d    = IDLE;
        grant_d    = 4'b0000;
        grant_id_d = 2'd0;
      end
    endcase

    grant_valid_d = |grant_d;
  end

  // State and output registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pointer_q     <= 2'd0;
      grant_q       <= 4'b0000;
      grant_valid_q <= 1'b0;
      grant_id_q    <= 2'd0;
`ifdef SHARED_BUS_ARBITER_TIMEOUT_EN
      hold_cnt_q    <= 8'd0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pointer_q     <= pointer_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
`ifdef SHARED_BUS_ARBITER_TIMEOUT_EN
      hold_cnt_q    <= hold_cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

`ifdef SHARED_BUS_ARBITER_TIMEOUT_EN
  assign timeout_pulse = timeout_q;
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_bus_arbiter
//
// Directed testbench for shared_bus_arbiter with MAX_HOLD = 4. Inputs are
// driven on the falling edge. Outputs are checked 1 ns after the rising
// edge that consumed those inputs. Expected values are written by hand.
// Where the forced-revoke build behaves differently, the expected values
// depend on SHARED_BUS_ARBITER_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_shared_bus_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout_pulse;

  int compared;
  int mismatched;

  shared_bus_arbiter #(
    .MAX_HOLD(4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .timeout_pulse (timeout_pulse)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit, so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected owner index for a one-hot grant. A zero grant maps to 0.
  function automatic logic [1:0] idOf(input logic [3:0] g);
    case (g)
      4'b0010: idOf = 2'd1;
      4'b0100: idOf = 2'd2;
      4'b1000: idOf = 2'd3;
      default: idOf = 2'd0;
    endcase
  endfunction

  // Drive one cycle of inputs, then land 1 ns after the rising edge that
  // sampled them.
  task automatic applyStimulus(input logic [3:0] r, input logic rn);
    @(negedge clk);
    req     = r;
    reset_n = rn;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the expected grant and pulse. The
  // expected grant_valid and grant_id are derived from the expected grant.
  task automatic checkOutput(input string tag, input logic [3:0] expGrant,
                             input logic expTimeout);
    logic [7:0] observed;
    logic [7:0] expected;
    observed = {grant, grant_valid, grant_id, timeout_pulse};
    expected = {expGrant, |expGrant, idOf(expGrant), expTimeout};
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b (grant,valid,id,timeout)",
             tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    req        = 4'b0000;
    reset_n    = 1'b0;

    // Reset state.
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("reset_state", 4'b0000, 1'b0);

    // A single request is granted one cycle after it is sampled.
    applyStimulus(4'b0001, 1'b1);
    checkOutput("single_req_grant", 4'b0001, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_req_release", 4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("idle_no_req", 4'b0000, 1'b0);

    // Round robin with all four requesting. Each owner holds the bus for
    // three cycles, then drops its request for one cycle.
    applyStimulus(4'b0000, 1'b0);
    checkOutput("rr_reset", 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1111, 1'b1);
      checkOutput("rr_grant_c1", 4'b0001 << k, 1'b0);
      applyStimulus(4'b1111, 1'b1);
      checkOutput("rr_grant_c2", 4'b0001 << k, 1'b0);
      applyStimulus(4'b1111, 1'b1);
      checkOutput("rr_grant_c3", 4'b0001 << k, 1'b0);
      applyStimulus(4'b1111 & ~(4'b0001 << k), 1'b1);
      checkOutput("rr_bubble", 4'b0000, 1'b0);
    end
    applyStimulus(4'b1111, 1'b1);
    checkOutput("rr_wrap_to_0", 4'b0001, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("rr_release", 4'b0000, 1'b0);

    // Contended owner: req0 is held and req2 is raised during the grant.
    applyStimulus(4'b0000, 1'b0);
    checkOutput("to_reset", 4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("to_hold1", 4'b0001, 1'b0);
    applyStimulus(4'b0101, 1'b1);
    checkOutput("to_hold2", 4'b0001, 1'b0);
    applyStimulus(4'b0101, 1'b1);
    checkOutput("to_hold3", 4'b0001, 1'b0);
    applyStimulus(4'b0101, 1'b1);
    checkOutput("to_hold4", 4'b0001, 1'b0);
`ifdef SHARED_BUS_ARBITER_TIMEOUT_EN
    applyStimulus(4'b0101, 1'b1);
    checkOutput("to_revoke", 4'b0000, 1'b1);
    applyStimulus(4'b0101, 1'b1);
    checkOutput("to_new_owner", 4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("to_owner2_c2", 4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("to_owner2_c3", 4'b0100, 1'b0);
`else
    applyStimulus(4'b0101, 1'b1);
    checkOutput("noto_hold5", 4'b0001, 1'b0);
    applyStimulus(4'b0101, 1'b1);
    checkOutput("noto_hold6", 4'b0001, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("noto_release", 4'b0000, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("noto_new_owner", 4'b0100, 1'b0);
`endif
    applyStimulus(4'b0000, 1'b1);
    checkOutput("to_release2", 4'b0000, 1'b0);
    // The pointer now sits at 3, so the search wraps past 3 to requester 0.
    applyStimulus(4'b0011, 1'b1);
    checkOutput("ptr_wrap", 4'b0001, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("ptr_wrap_release", 4'b0000, 1'b0);

    // The owner drops its request on the same cycle a revoke would fire.
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("drop_at_max_g1", 4'b0001, 1'b0);
    applyStimulus(4'b0011, 1'b1);
    applyStimulus(4'b0011, 1'b1);
    applyStimulus(4'b0011, 1'b1);
    checkOutput("drop_at_max_g4", 4'b0001, 1'b0);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("drop_at_max_no_pulse", 4'b0000, 1'b0);
    applyStimulus(4'b0010, 1'b1);
    checkOutput("drop_at_max_next", 4'b0010, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("drop_at_max_release", 4'b0000, 1'b0);

    // An uncontended owner keeps the bus well past MAX_HOLD.
    applyStimulus(4'b0000, 1'b0);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(4'b0001, 1'b1);
      checkOutput("solo_hold", 4'b0001, 1'b0);
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("solo_release", 4'b0000, 1'b0);

    // Reset during a grant to requester 2, then a fresh search from 0.
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("rst_mid_g1", 4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("rst_mid_g2", 4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("rst_mid_drop", 4'b0000, 1'b0);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("rst_mid_regrant", 4'b0010, 1'b0);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("rst_mid_release", 4'b0000, 1'b0);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("rst_mid_next", 4'b1000, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("final_idle", 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
